// File: rtl/i2c_xfer_seq_pkg.sv
// Shared constants and types for the I2C transaction sequencer: core register map,
// command bytes, status bit positions, error codes and sequencer states.
package i2c_seq_pkg;

   localparam logic [2:0] ADR_PRER_LO = 3'd0;
   localparam logic [2:0] ADR_PRER_HI = 3'd1;
   localparam logic [2:0] ADR_CTR     = 3'd2;
   localparam logic [2:0] ADR_TXR_RXR = 3'd3;
   localparam logic [2:0] ADR_CR_SR   = 3'd4;

   localparam logic [7:0] CTR_EN          = 8'h80;
   localparam logic [7:0] CMD_STA_WR      = 8'h90;
   localparam logic [7:0] CMD_WR          = 8'h10;
   localparam logic [7:0] CMD_STO_WR      = 8'h50;
   localparam logic [7:0] CMD_RD_NACK_STO = 8'h68;
   localparam logic [7:0] CMD_STO         = 8'h40;

   localparam int SR_RXACK = 7;
   localparam int SR_BUSY  = 6;
   localparam int SR_AL    = 5;
   localparam int SR_TIP   = 1;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_NACK    = 2'd1,
      ERR_AL      = 2'd2,
      ERR_TIMEOUT = 2'd3
   } rsp_err_e;

   typedef enum logic [3:0] {
      S_INIT       = 4'd0,
      S_IDLE       = 4'd1,
      S_TXR        = 4'd2,
      S_CR         = 4'd3,
      S_WAIT       = 4'd4,
      S_RXR        = 4'd5,
      S_ABORT      = 4'd6,
      S_ABORT_WAIT = 4'd7,
      S_DONE       = 4'd8
   } seq_state_e;

endpackage

// File: rtl/i2c_xfer_seq_if.sv
// Wishbone link between the sequencer (master) and the I2C core's 3-bit slave port.
interface i2c_xfer_seq_if;
   logic       wbm_cyc_o;
   logic       wbm_stb_o;
   logic       wbm_we_o;
   logic [2:0] wbm_adr_o;
   logic [7:0] wbm_dat_o;
   logic [7:0] wbm_dat_i;
   logic       wbm_ack_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface

// File: rtl/i2c_wb_bus_op.sv
// Single-access Wishbone master: one start launches one read or write, done pulses
// the cycle after ack with the captured read data.
module i2c_wb_bus_op (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  we_i,
   input  logic [2:0]            adr_i,
   input  logic [7:0]            dat_i,
   output logic                  done_o,
   output logic [7:0]            rdata_o,
   i2c_xfer_seq_if.master        wb
);

   logic       cyc_q;
   logic       we_q;
   logic [2:0] adr_q;
   logic [7:0] dat_q;
   logic       done_q;
   logic [7:0] rdata_q;

   // Bus cycle engine: hold the access until ack, then drop and report.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= 3'd0;
         dat_q   <= 8'h00;
         done_q  <= 1'b0;
         rdata_q <= 8'h00;
      end else begin
         done_q <= 1'b0;
         if (cyc_q && wb.wbm_ack_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 3'd0;
            dat_q   <= 8'h00;
            rdata_q <= wb.wbm_dat_i;
            done_q  <= 1'b1;
         end else if (!cyc_q && start_i) begin
            cyc_q <= 1'b1;
            we_q  <= we_i;
            adr_q <= adr_i;
            dat_q <= dat_i;
         end
      end
   end

   assign wb.wbm_cyc_o = cyc_q;
   assign wb.wbm_stb_o = cyc_q;
   assign wb.wbm_we_o  = we_q;
   assign wb.wbm_adr_o = adr_q;
   assign wb.wbm_dat_o = dat_q;
   assign done_o       = done_q;
   assign rdata_o      = rdata_q;

endmodule

// File: rtl/i2c_xfer_seq.sv
// Sequences the I2C master core through init plus one-register write or
// repeated-start read transactions, polling SR for completion and errors.
module i2c_xfer_seq
   import i2c_seq_pkg::*;
#(
   parameter logic [15:0] PRESCALE = 16'd99,
   parameter int          POLL_MAX = 1024
) (
   input  logic            wb_clk_i,
   input  logic            arst_i,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_rnw,
   input  logic [6:0]      req_dev,
   input  logic [7:0]      req_reg,
   input  logic [7:0]      req_wdata,
   output logic            rsp_valid,
   output logic [7:0]      rsp_rdata,
   output logic [1:0]      rsp_err,
   i2c_xfer_seq_if.master  wbm
);

   localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);

   seq_state_e state_q;
   logic [1:0] step_q;
   logic       pend_q;
   logic [15:0] poll_q;
   logic       rnw_q;
   logic [6:0] dev_q;
   logic [7:0] reg_q, wdata_q, rx_q;
   rsp_err_e   err_q;
   logic       start_q, op_we_q;
   logic [2:0] op_adr_q;
   logic [7:0] op_dat_q;
   logic       req_ready_q, rsp_valid_q;
   logic [7:0] rsp_rdata_q;
   logic [1:0] rsp_err_q;

   logic       op_done_s, op_fin_s, op_state_s, last_step_s, poll_last_s;
   logic [7:0] op_rdata_s, txr_byte_s, cr_cmd_s, init_byte_s, op_dat_s;
   logic       op_we_s;
   logic [2:0] op_adr_s;

   i2c_wb_bus_op u_bus_op (
      .clk_i   (wb_clk_i),
      .rst_ni  (arst_i),
      .start_i (start_q),
      .we_i    (op_we_q),
      .adr_i   (op_adr_q),
      .dat_i   (op_dat_q),
      .done_o  (op_done_s),
      .rdata_o (op_rdata_s),
      .wb      (wbm)
   );

   assign op_fin_s    = pend_q & op_done_s;
   assign last_step_s = rnw_q ? (step_q == 2'd3) : (step_q == 2'd2);
   assign poll_last_s = ((poll_q + 16'd1) == POLL_LIM);

   // Byte selection for each step; read step 3 has no TXR write.
   always_comb begin
      txr_byte_s  = 8'h00;
      cr_cmd_s    = 8'h00;
      init_byte_s = CTR_EN;
      case (step_q)
         2'd0: begin
            txr_byte_s  = {dev_q, 1'b0};
            cr_cmd_s    = CMD_STA_WR;
            init_byte_s = PRESCALE[7:0];
         end
         2'd1: begin
            txr_byte_s  = reg_q;
            cr_cmd_s    = CMD_WR;
            init_byte_s = PRESCALE[15:8];
         end
         2'd2: begin
            txr_byte_s  = rnw_q ? {dev_q, 1'b1} : wdata_q;
            cr_cmd_s    = rnw_q ? CMD_STA_WR : CMD_STO_WR;
            init_byte_s = CTR_EN;
         end
         default: begin
            txr_byte_s  = 8'h00;
            cr_cmd_s    = CMD_RD_NACK_STO;
            init_byte_s = CTR_EN;
         end
      endcase
   end

   // Which bus access the current state performs.
   always_comb begin
      op_state_s = 1'b1;
      op_we_s    = 1'b1;
      op_adr_s   = ADR_CR_SR;
      op_dat_s   = 8'h00;
      case (state_q)
         S_INIT:       begin op_adr_s = {1'b0, step_q}; op_dat_s = init_byte_s; end
         S_TXR:        begin op_adr_s = ADR_TXR_RXR; op_dat_s = txr_byte_s; end
         S_CR:         op_dat_s = cr_cmd_s;
         S_WAIT:       op_we_s = 1'b0;
         S_RXR:        begin op_we_s = 1'b0; op_adr_s = ADR_TXR_RXR; end
         S_ABORT:      op_dat_s = CMD_STO;
         S_ABORT_WAIT: op_we_s = 1'b0;
         default:      op_state_s = 1'b0;
      endcase
   end

   // Sequencer FSM; each op state issues once, then reacts to the completed access.
   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state_q     <= S_INIT;
         step_q      <= 2'd0;
         pend_q      <= 1'b0;
         poll_q      <= 16'd0;
         rnw_q       <= 1'b0;
         dev_q       <= 7'd0;
         reg_q       <= 8'h00;
         wdata_q     <= 8'h00;
         rx_q        <= 8'h00;
         err_q       <= ERR_OK;
         start_q     <= 1'b0;
         op_we_q     <= 1'b0;
         op_adr_q    <= 3'd0;
         op_dat_q    <= 8'h00;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         rsp_err_q   <= 2'd0;
      end else begin
         start_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         if (op_state_s && !pend_q) begin
            start_q  <= 1'b1;
            pend_q   <= 1'b1;
            op_we_q  <= op_we_s;
            op_adr_q <= op_adr_s;
            op_dat_q <= op_dat_s;
         end
         if (op_fin_s) pend_q <= 1'b0;
         case (state_q)
            S_INIT: if (op_fin_s) begin
               step_q <= step_q + 2'd1;
               if (step_q == 2'd2) begin
                  step_q  <= 2'd0;
                  state_q <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (req_ready_q && req_valid) begin
                  req_ready_q <= 1'b0;
                  rnw_q       <= req_rnw;
                  dev_q       <= req_dev;
                  reg_q       <= req_reg;
                  wdata_q     <= req_wdata;
                  step_q      <= 2'd0;
                  err_q       <= ERR_OK;
                  rx_q        <= 8'h00;
                  state_q     <= S_TXR;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            S_TXR: if (op_fin_s) state_q <= S_CR;
            S_CR: if (op_fin_s) begin
               poll_q  <= 16'd0;
               state_q <= S_WAIT;
            end
            S_WAIT: if (op_fin_s) begin
               poll_q <= poll_q + 16'd1;
               // AL outranks TIP and RXACK: the core has already let go of the bus.
               if (op_rdata_s[SR_AL]) begin
                  err_q   <= ERR_AL;
                  state_q <= S_DONE;
               end else if (!op_rdata_s[SR_TIP]) begin
                  if (!last_step_s && op_rdata_s[SR_RXACK]) begin
                     err_q   <= ERR_NACK;
                     state_q <= S_ABORT;
                  end else if (last_step_s) begin
                     state_q <= rnw_q ? S_RXR : S_DONE;
                  end else begin
                     step_q  <= step_q + 2'd1;
                     state_q <= (rnw_q && step_q == 2'd2) ? S_CR : S_TXR;
                  end
               end else if (poll_last_s) begin
                  err_q   <= ERR_TIMEOUT;
                  state_q <= S_ABORT;
               end
            end
            S_RXR: if (op_fin_s) begin
               rx_q    <= op_rdata_s;
               state_q <= S_DONE;
            end
            S_ABORT: if (op_fin_s) begin
               poll_q  <= 16'd0;
               state_q <= S_ABORT_WAIT;
            end
            S_ABORT_WAIT: if (op_fin_s) begin
               poll_q <= poll_q + 16'd1;
               if (!op_rdata_s[SR_BUSY] || poll_last_s) state_q <= S_DONE;
            end
            S_DONE: begin
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= (rnw_q && err_q == ERR_OK) ? rx_q : 8'h00;
               rsp_err_q   <= err_q;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed bench for i2c_xfer_seq against a small I2C-core Wishbone model.
module tb_i2c_xfer_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0, req_ready, req_rnw = 1'b0;
   logic [6:0] req_dev = 7'd0;
   logic [7:0] req_reg = 8'h00, req_wdata = 8'h00;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_err;

   i2c_xfer_seq_if bus();

   i2c_xfer_seq #(.PRESCALE(16'd99), .POLL_MAX(4)) dut (
      .wb_clk_i(clk), .arst_i(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
      .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .wbm(bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;

   // Core model configuration (written by the stimulus only)
   bit         clr_req = 1'b0;
   int         nack_at = 0, al_at = 0;
   bit         tip_stuck = 1'b0;
   logic [7:0] rx_byte = 8'h00;

   // Core model state and access log
   logic       ack = 1'b0;
   logic [7:0] rdat = 8'h00;
   int         cr_cnt, txr_cnt, sr_reads, sr_pre_sto, tip_left, busy_left, log_n;
   bit         sto_seen;
   logic [31:0] txr_seq, cr_seq;
   logic [11:0] log_q [0:15];

   assign bus.wbm_ack_i = ack;
   assign bus.wbm_dat_i = rdat;

   always @(posedge clk) begin
      if (!rst_n || clr_req) begin
         ack <= 1'b0; rdat <= 8'h00;
         cr_cnt <= 0; txr_cnt <= 0; sr_reads <= 0; sr_pre_sto <= 0;
         tip_left <= 0; busy_left <= 0; log_n <= 0; sto_seen <= 1'b0;
         txr_seq <= 32'd0; cr_seq <= 32'd0;
      end else begin
         ack <= 1'b0;
         if (bus.wbm_cyc_o && bus.wbm_stb_o && !ack) begin
            ack <= 1'b1;
            if (log_n < 16) begin
               log_q[log_n] <= {bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o};
               log_n <= log_n + 1;
            end
            if (bus.wbm_we_o) begin
               rdat <= 8'h00;
               if (bus.wbm_adr_o == 3'd3) begin
                  txr_seq <= {txr_seq[23:0], bus.wbm_dat_o};
                  txr_cnt <= txr_cnt + 1;
               end
               if (bus.wbm_adr_o == 3'd4) begin
                  cr_seq   <= {cr_seq[23:0], bus.wbm_dat_o};
                  cr_cnt   <= cr_cnt + 1;
                  tip_left <= 1;
                  if (bus.wbm_dat_o == 8'h40) begin
                     busy_left <= 1;
                     sto_seen  <= 1'b1;
                  end
               end
            end else if (bus.wbm_adr_o == 3'd4) begin
               sr_reads <= sr_reads + 1;
               if (!sto_seen) sr_pre_sto <= sr_pre_sto + 1;
               rdat <= {(nack_at != 0 && cr_cnt == nack_at), (busy_left != 0),
                        (al_at != 0 && cr_cnt == al_at), 3'b000,
                        (tip_stuck || tip_left != 0), 1'b0};
               if (tip_left > 0) tip_left <= tip_left - 1;
               if (busy_left > 0) busy_left <= busy_left - 1;
            end else if (bus.wbm_adr_o == 3'd3) begin
               rdat <= rx_byte;
            end else begin
               rdat <= 8'h00;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      @(negedge clk); clr_req = 1'b1;
      @(negedge clk); clr_req = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      bit got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clk);
         if (req_ready) got = 1'b1;
      end
      chk(tag, {31'd0, got}, 32'd1);
   endtask

   task automatic check_init(input string pfx);
      wait_ready({pfx, "_ready"});
      repeat (4) @(negedge clk);
      chk({pfx, "_nacc"}, log_n, 32'd3);
      chk({pfx, "_w0"}, {20'd0, log_q[0]}, 32'h863);
      chk({pfx, "_w1"}, {20'd0, log_q[1]}, 32'h900);
      chk({pfx, "_w2"}, {20'd0, log_q[2]}, 32'hA80);
   endtask

   task automatic send_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input string pfx);
      wait_ready({pfx, "_ready"});
      @(negedge clk);
      req_valid = 1'b1; req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      chk({pfx, "_rdy_drop"}, {31'd0, req_ready}, 32'd0);
   endtask

   task automatic do_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input string pfx,
                         output logic [7:0] rd, output logic [1:0] er);
      bit got = 1'b0;
      int pulses = 0;
      rd = 8'hxx; er = 2'bxx;
      clear_model();
      send_req(rnw, dev, rg, wd, pfx);
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1; pulses++; rd = rsp_rdata; er = rsp_err;
         end
      end
      chk({pfx, "_rsp_seen"}, {31'd0, got}, 32'd1);
      @(negedge clk);
      chk({pfx, "_rdy_back"}, {31'd0, req_ready}, 32'd1);
      if (rsp_valid) pulses++;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      chk({pfx, "_pulses"}, pulses, 32'd1);
   endtask

   logic [7:0] rd;
   logic [1:0] er;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_cyc", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd0);
      chk("rst_rdy", {30'd0, req_ready, rsp_valid}, 32'd0);
      rst_n = 1'b1;
      check_init("init");

      // Plain register write
      do_req(1'b0, 7'h50, 8'h12, 8'hA5, "wr", rd, er);
      chk("wr_txr", txr_seq, 32'h00A012A5);
      chk("wr_cr", cr_seq, 32'h00901050);
      chk("wr_ncr", cr_cnt, 32'd3);
      chk("wr_sr", sr_reads, 32'd6);
      chk("wr_err", {30'd0, er}, 32'd0);
      chk("wr_rdata", {24'd0, rd}, 32'd0);

      // Repeated-start register read
      rx_byte = 8'h5C;
      do_req(1'b1, 7'h50, 8'h34, 8'h00, "rd", rd, er);
      chk("rd_txr", txr_seq, 32'h00A034A1);
      chk("rd_cr", cr_seq, 32'h90109068);
      chk("rd_ntxr", txr_cnt, 32'd3);
      chk("rd_sr", sr_reads, 32'd8);
      chk("rd_err", {30'd0, er}, 32'd0);
      chk("rd_rdata", {24'd0, rd}, 32'h5C);

      // Address NACK -> stop issued, busy polled clear
      nack_at = 1;
      do_req(1'b0, 7'h50, 8'h12, 8'h77, "nack", rd, er);
      chk("nack_txr", txr_seq, 32'h000000A0);
      chk("nack_ntxr", txr_cnt, 32'd1);
      chk("nack_cr", cr_seq, 32'h00009040);
      chk("nack_sr", sr_reads, 32'd4);
      chk("nack_err", {30'd0, er}, 32'd1);
      chk("nack_rdata", {24'd0, rd}, 32'd0);
      nack_at = 0;

      // Arbitration lost on the register byte -> no stop
      al_at = 2;
      do_req(1'b0, 7'h50, 8'h12, 8'h77, "al", rd, er);
      chk("al_txr", txr_seq, 32'h0000A012);
      chk("al_cr", cr_seq, 32'h00009010);
      chk("al_sr", sr_reads, 32'd3);
      chk("al_err", {30'd0, er}, 32'd2);
      al_at = 0;

      do_req(1'b0, 7'h22, 8'h01, 8'h3C, "post_al", rd, er);
      chk("post_al_txr", txr_seq, 32'h0044013C);
      chk("post_al_cr", cr_seq, 32'h00901050);
      chk("post_al_err", {30'd0, er}, 32'd0);

      // TIP stuck -> POLL_MAX reads then stop, timeout
      tip_stuck = 1'b1;
      do_req(1'b1, 7'h50, 8'h34, 8'h00, "tmo", rd, er);
      chk("tmo_presto", sr_pre_sto, 32'd4);
      chk("tmo_cr", cr_seq, 32'h00009040);
      chk("tmo_ntxr", txr_cnt, 32'd1);
      chk("tmo_err", {30'd0, er}, 32'd3);
      chk("tmo_rdata", {24'd0, rd}, 32'd0);
      tip_stuck = 1'b0;

      // Async reset in the middle of a read
      begin
         bit got = 1'b0;
         clear_model();
         send_req(1'b1, 7'h50, 8'h34, 8'h00, "arst");
         for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (cr_cnt >= 2 && bus.wbm_cyc_o) got = 1'b1;
         end
         chk("arst_midbus", {31'd0, got}, 32'd1);
         #2 rst_n = 1'b0;
         #1;
         chk("arst_bus", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o}, 32'd0);
         chk("arst_rsp", {req_ready, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         check_init("reinit");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
